// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if: instruction/control handshake and writeback result bus
interface multicycle_datapath_if #(
    parameter int WIDTH = 32
);
    logic [25:0] inst;
    logic inst_valid, inst_ready;
    logic regdst, alusrc, memwrite, memread, memtoreg, regwrite;
    logic [2:0] alucontrol;
    logic [WIDTH-1:0] out;
    logic out_valid, exc;
    modport master (
        output inst, inst_valid, regdst, alusrc, memwrite, memread, memtoreg, regwrite, alucontrol,
        input inst_ready, out, out_valid, exc
    );
    modport slave (
        input inst, inst_valid, regdst, alusrc, memwrite, memread, memtoreg, regwrite, alucontrol,
        output inst_ready, out, out_valid, exc
    );
endinterface

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: unpipelined IDLE/DECODE/EXEC/MEM/WB datapath with 32-entry register file and data memory.
// Define OVF_TRAP_EN to trap signed ADD/SUB overflow (write/memory suppressed, EXC pulsed).
module multicycle_datapath #(
    parameter int WIDTH = 32,
    parameter int MEM_DEPTH = 256
) (
    input logic clk,
    input logic rst_n,
    multicycle_datapath_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4;
    logic [2:0] state;
    logic [25:0] inst;
    logic regdst, alusrc, memwrite, memread, memtoreg, regwrite;
    logic [2:0] alucontrol;
    logic [WIDTH-1:0] regs [32];
    logic [WIDTH-1:0] mem [MEM_DEPTH];
    logic [WIDTH-1:0] a, b, alu_out, mdr, imm_ext, op2, sum, diff, alu_res, wb_val;
    logic [4:0] rs, rt, rd, wa;
    logic ovf, trap_q;
    always_comb begin
        rs = inst[25:21];
        rt = inst[20:16];
        rd = inst[15:11];
        wa = regdst ? rd : rt;
        imm_ext = WIDTH'($signed(inst[15:0]));
        op2 = alusrc ? imm_ext : b;
        sum = a + op2;
        diff = a - op2;
        alu_res = alucontrol == 3'b000 ? a & op2 :
                  alucontrol == 3'b001 ? a | op2 :
                  alucontrol == 3'b010 ? sum :
                  alucontrol == 3'b110 ? diff :
                  alucontrol == 3'b111 ? WIDTH'($signed(a) < $signed(op2)) : '0;
        wb_val = (memtoreg && !trap_q) ? mdr : alu_out;
    end
`ifdef OVF_TRAP_EN
    assign ovf = (alucontrol == 3'b010 && a[WIDTH-1] == op2[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) ||
                 (alucontrol == 3'b110 && a[WIDTH-1] != op2[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            bus.exc <= 1'b0;
        end else begin
            if (state == EXEC) trap_q <= ovf;
            bus.exc <= state == WB && trap_q;
        end
    end
`else
    assign ovf = 1'b0;
    assign trap_q = 1'b0;
    assign bus.exc = 1'b0;
`endif
    assign bus.inst_ready = state == IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a <= '0;
            b <= '0;
            alu_out <= '0;
            mdr <= '0;
            bus.out <= '0;
            bus.out_valid <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: if (bus.inst_valid) begin
                    inst <= bus.inst;
                    {regdst, alusrc, memwrite, memread, memtoreg, regwrite} <=
                        {bus.regdst, bus.alusrc, bus.memwrite, bus.memread, bus.memtoreg, bus.regwrite};
                    alucontrol <= bus.alucontrol;
                    state <= DECODE;
                end
                DECODE: begin
                    a <= rs == 5'd0 ? '0 : regs[rs];
                    b <= rt == 5'd0 ? '0 : regs[rt];
                    state <= EXEC;
                end
                EXEC: begin
                    alu_out <= alu_res;
                    state <= ((memread || memwrite) && !ovf) ? MEM : WB;
                end
                MEM: begin
                    if (memread) mdr <= mem[alu_out[AW-1:0]];
                    state <= WB;
                end
                WB: begin
                    if (regwrite && !trap_q && wa != 5'd0) regs[wa] <= wb_val;
                    bus.out <= wb_val;
                    bus.out_valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Memory is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && state == MEM && memwrite) mem[alu_out[AW-1:0]] <= b;
    end
endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter: WIDTH, default 32, data path, register and memory word width (>=8).
REQ-002 Parameter: MEM_DEPTH, default 256, data memory words; power of two, 2..2^16.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset; synchronous, active-low.
REQ-005 INST  input  26  rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
REQ-006 INST_VALID  input  1  INST and control inputs are valid this cycle.
REQ-007 INST_READY  output  1  block accepts an instruction this cycle.
REQ-008 REGDST, ALUSRC, MEMWRITE, MEMREAD, MEMTOREG, REGWRITE  input  1 each  control bits, same meaning as the single-cycle datapath.
REQ-009 ALUCONTROL  input  3  ALU operation select.
REQ-010 OUT  output  WIDTH  writeback value of the last completed instruction.
REQ-011 OUT_VALID  output  1  one-cycle pulse when OUT updates.
REQ-012 EXC  output  1  one-cycle overflow-trap pulse (only with OVF_TRAP_EN).

Function
REQ-013 Accept occurs on the edge where INST_VALID=1 and INST_READY=1; INST and all control bits are latched then and held until the instruction retires.
REQ-014 INST_READY shall be 1 only in state IDLE; there is no pipelining and at most one instruction is in flight.
REQ-015 States: IDLE -> DECODE -> EXEC -> (MEM if MEMREAD|MEMWRITE) -> WB -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-016 DECODE: register A <= reg[rs], B <= reg[rt]; reg[0] shall always read 0 and writes to it shall be discarded.
REQ-017 Immediate: imm sign-extended to WIDTH; operand2 = ALUSRC ? imm_ext : B.
REQ-018 EXEC: ALUOUT <= f(A, operand2): 000 AND, 001 OR, 010 ADD, 110 SUB, 111 signed SLT (1/0); other codes yield 0; ADD/SUB wrap modulo 2^WIDTH.
REQ-019 MEM: word address = ALUOUT[log2(MEM_DEPTH)-1:0], upper bits ignored (wrap-around); MEMWRITE writes B; MEMREAD registers mem[addr] into MDR; if both are set, the read returns the old data.
REQ-020 WB: value = MEMTOREG ? MDR : ALUOUT; if REGWRITE, reg[REGDST ? rd : rt] <= value; OUT <= value and OUT_VALID=1 in the WB cycle regardless of REGWRITE.
REQ-021 Latency: OUT_VALID is high in the 4th cycle after the accept edge for non-memory instructions and the 5th for memory instructions; the next accept is possible in the following cycle.
REQ-022 Register file write in WB is visible to a DECODE read of the next instruction (no hazard possible).
REQ-023 INST_VALID while not ready shall be ignored; the source holds it until accepted.

Reset
REQ-024 RST_N=0 at an edge: state<=IDLE, all 32 registers<=0, A/B/ALUOUT/MDR<=0, OUT<=0, OUT_VALID<=0, EXC<=0; INST_READY=1 in the first cycle after release.
REQ-025 Reset mid-instruction shall abandon it with no register write; a memory write already performed in MEM stays; memory contents are not cleared by reset.

Configuration
REQ-026 Macro OVF_TRAP_EN: when defined, signed overflow on ADD/SUB in EXEC shall suppress the register write and memory access of that instruction, go straight to WB, pulse EXC with OUT_VALID, and drive OUT with the wrapped result.
REQ-027 Without OVF_TRAP_EN, EXC is tied to 0 and overflowing results are written normally.

Verification
REQ-028 Reset, then ADD r1=r0+imm 5 (ALUSRC=1, REGDST=0, rt=1, ALUCONTROL=010, REGWRITE=1) -> OUT=5, OUT_VALID on cycle 4 after accept, reg1=5.
REQ-029 Store r1 to imm 3 then load imm 3 into r2 -> OUT=5 on cycle 5 of the load; reg2=5.
REQ-030 WIDTH=32, MEM_DEPTH=256, store to address 259 then load from 3 -> returns the stored value (wrap).
REQ-031 Write to r0 with 7, then ADD r3=r0+r0 -> OUT=0.
REQ-032 Hold INST_VALID high continuously -> INST_READY low in non-IDLE states, exactly one accept per retire, no instruction lost or duplicated.
REQ-033 With OVF_TRAP_EN: 0x7FFFFFFF+1 into r4 -> EXC=1, OUT=0x80000000, r4 unchanged; without it: r4=0x80000000, EXC=0; RST_N low during EXEC -> no write, IDLE next cycle.
